// File: rtl/isa_pkg.sv
// Shared ISA constants, instruction layout and fetch FSM state type for the
// instruction fetch unit.
package isa_pkg;

   localparam int INSTR_W = 14;
   localparam int ADDR_W  = 6;

   localparam int OPC_MSB = 13;
   localparam int OPC_LSB = 10;

   localparam logic [3:0]         OPC_NOP   = 4'hE;
   localparam logic [3:0]         OPC_HALT  = 4'hF;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 14'h3800;

   typedef struct packed {
      logic [3:0] opcode;
      logic [1:0] rd;
      logic [7:0] imm;
   } instr_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } fetch_state_e;

   function automatic logic is_halt(input logic [INSTR_W-1:0] word);
      return word[OPC_MSB:OPC_LSB] == OPC_HALT;
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus between the fetch unit and its environment: program load, run control,
// core feedback (stall/jump) and the instruction stream to the core.
interface instr_fetch_unit_if
   import isa_pkg::*;
#(
   parameter int AW = ADDR_W,
   parameter int IW = INSTR_W
);
   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [IW-1:0] prog_data;
   logic          start;
   logic          halt_req;
   logic          stall;
   logic          jmp_en;
   logic [AW-1:0] jmp_addr;
   logic [IW-1:0] instr;
   logic          instr_valid;
   logic [AW-1:0] pc;
   logic          running;
   logic          done;

   modport master (
      output prog_we, prog_addr, prog_data, start, halt_req, stall, jmp_en, jmp_addr,
      input  instr, instr_valid, pc, running, done
   );

   modport slave (
      input  prog_we, prog_addr, prog_data, start, halt_req, stall, jmp_en, jmp_addr,
      output instr, instr_valid, pc, running, done
   );
endinterface

// File: rtl/instr_fetch_unit_prog_mem.sv
// Program memory for the fetch unit: 2**AW x IW words, synchronous write,
// combinational read.
module prog_mem
   import isa_pkg::*;
#(
   parameter int AW = ADDR_W,
   parameter int IW = INSTR_W
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [IW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [IW-1:0] rdata
);

   logic [IW-1:0] mem [2**AW];

   // NOTE: the array has no reset so it maps onto RAM and keeps its program across rst.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Self-sequencing instruction fetch: program memory, PC and IDLE/RUN/DONE FSM.
// Define FETCH_LOOP_EN to make a HALT opcode restart the program at address 0.
module instr_fetch_unit
   import isa_pkg::*;
#(
   parameter int AW = ADDR_W,
   parameter int IW = INSTR_W
) (
   input logic               clk,
   input logic               rst,
   instr_fetch_unit_if.slave bus
);

   fetch_state_e  state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [IW-1:0] instr_q, instr_d;
   logic          valid_q, valid_d;
   logic          mem_we;
   logic [IW-1:0] rd_data;

   prog_mem #(.AW(AW), .IW(IW)) u_prog_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (bus.prog_addr),
      .wdata (bus.prog_data),
      .raddr (pc_q),
      .rdata (rd_data)
   );

   // NOTE: every variable gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      mem_we  = 1'b0;

      unique case (state_q)
         S_RUN: begin
            if (bus.halt_req) begin
               state_d = S_DONE;
               instr_d = NOP_INSTR;
               valid_d = 1'b0;
            end else if (bus.jmp_en) begin
               pc_d    = bus.jmp_addr;
               instr_d = NOP_INSTR;
               valid_d = 1'b0;
            end else if (!bus.stall) begin
               if (is_halt(rd_data)) begin
                  // HALT is swallowed; the core only ever sees a bubble.
                  instr_d = NOP_INSTR;
                  valid_d = 1'b0;
`ifdef FETCH_LOOP_EN
                  pc_d    = '0;
`else
                  state_d = S_DONE;
`endif
               end else begin
                  instr_d = rd_data;
                  valid_d = 1'b1;
                  pc_d    = pc_q + AW'(1);
               end
            end
         end
         default: begin
            // IDLE and DONE: program loading allowed, start launches from address 0.
            mem_we = bus.prog_we;
            if (bus.start) begin
               state_d = S_RUN;
               pc_d    = '0;
               instr_d = NOP_INSTR;
               valid_d = 1'b0;
            end
         end
      endcase
   end

   // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   assign bus.instr       = instr_q;
   assign bus.instr_valid = valid_q;
   assign bus.pc          = pc_q;
   assign bus.running     = (state_q == S_RUN);
   assign bus.done        = (state_q == S_DONE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus random
// stimulus, all compared every cycle against a behavioural reference model.
module tb_instr_fetch_unit;

   localparam int DEPTH = 64;
   localparam int NOP   = 'h3800;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   instr_fetch_unit_if #(.AW(6), .IW(14)) bus ();

   instr_fetch_unit #(.AW(6), .IW(14)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a word array and a few scalars describing what the core sees.
   int m_mem [DEPTH];
   bit m_run, m_done, m_valid;
   int m_pc, m_instr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check("instr",       32'(bus.instr),       32'(m_instr));
      check("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
      check("pc",          32'(bus.pc),          32'(m_pc));
      check("running",     32'(bus.running),     32'(m_run));
      check("done",        32'(bus.done),        32'(m_done));
   endtask

   task automatic model_reset();
      m_run   = 0;
      m_done  = 0;
      m_pc    = 0;
      m_instr = NOP;
      m_valid = 0;
   endtask

   function automatic void bubble();
      m_instr = NOP;
      m_valid = 0;
   endfunction

   task automatic model_step();
      if (!m_run) begin
         if (bus.prog_we) m_mem[int'(bus.prog_addr)] = int'(bus.prog_data);
         if (bus.start) begin
            m_run  = 1;
            m_done = 0;
            m_pc   = 0;
            bubble();
         end
      end else if (bus.halt_req) begin
         m_run  = 0;
         m_done = 1;
         bubble();
      end else if (bus.jmp_en) begin
         m_pc = int'(bus.jmp_addr);
         bubble();
      end else if (!bus.stall) begin
         if (m_mem[m_pc] / 1024 == 15) begin
            bubble();
`ifdef FETCH_LOOP_EN
            m_pc = 0;
`else
            m_run  = 0;
            m_done = 1;
`endif
         end else begin
            m_instr = m_mem[m_pc];
            m_valid = 1;
            m_pc    = (m_pc + 1) % DEPTH;
         end
      end
   endtask

   task automatic idle_inputs();
      bus.prog_we   = 1'b0;
      bus.prog_addr = '0;
      bus.prog_data = '0;
      bus.start     = 1'b0;
      bus.halt_req  = 1'b0;
      bus.stall     = 1'b0;
      bus.jmp_en    = 1'b0;
      bus.jmp_addr  = '0;
   endtask

   // One clock: model follows the edge, outputs checked 1ns later, returns at negedge.
   task automatic tick();
      @(posedge clk);
      if (rst) model_step();
      #1;
      check_outputs();
      @(negedge clk);
   endtask

   task automatic write_word(input int addr, input int data);
      bus.prog_we   = 1'b1;
      bus.prog_addr = 6'(addr);
      bus.prog_data = 14'(data);
      tick();
      bus.prog_we   = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic pulse_halt();
      bus.halt_req = 1'b1;
      tick();
      bus.halt_req = 1'b0;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b0;
      model_reset();
      foreach (m_mem[i]) m_mem[i] = -1;
      #12;
      check_outputs();
      @(negedge clk);
      rst = 1'b1;

      // Whole memory filled without any HALT: PC must wrap 63 -> 0 with valid held high.
      for (int i = 0; i < DEPTH; i++) write_word(i, 'h2FC0);
      pulse_start();
      repeat (70) tick();
      pulse_halt();

      // Short program ending in HALT.
      write_word(0, 'h2801);
      write_word(1, 'h2902);
      write_word(2, 'h2A03);
      write_word(3, 'h3C00);
      pulse_start();
      repeat (6) tick();
      pulse_halt();

      // Stall for 3 cycles while 2902 is presented.
      pulse_start();
      repeat (2) tick();
      bus.stall = 1'b1;
      repeat (3) tick();
      bus.stall = 1'b0;
      repeat (2) tick();
      pulse_halt();

      // Jump while stalled: jump wins, one bubble, then mem[16].
      pulse_start();
      repeat (2) tick();
      bus.stall    = 1'b1;
      bus.jmp_en   = 1'b1;
      bus.jmp_addr = 6'h10;
      tick();
      bus.stall  = 1'b0;
      bus.jmp_en = 1'b0;
      repeat (3) tick();
      pulse_halt();

      // Asynchronous reset mid-run, observed between clock edges.
      pulse_start();
      repeat (2) tick();
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      check_outputs();
      tick();
      rst = 1'b1;
      tick();

      // Program write during RUN is ignored; halt_req mid-run; rerun proves mem[1] intact.
      pulse_start();
      tick();
      write_word(1, 'h3C00);
      pulse_halt();
      pulse_start();
      repeat (5) tick();
      pulse_halt();

      // Random program and random control traffic.
      for (int i = 0; i < DEPTH; i++) begin
         int word;
         word = int'($urandom_range(0, 16383));
         if ($urandom_range(0, 15) != 0 && word / 1024 == 15) word = word - 1024;
         write_word(i, word);
      end
      for (int c = 0; c < 3000; c++) begin
         bus.prog_we   = ($urandom_range(0, 3) == 0);
         bus.prog_addr = 6'($urandom_range(0, 63));
         bus.prog_data = 14'($urandom_range(0, 16383));
         bus.start     = ($urandom_range(0, 7) == 0);
         bus.halt_req  = ($urandom_range(0, 63) == 0);
         bus.stall     = ($urandom_range(0, 3) == 0);
         bus.jmp_en    = ($urandom_range(0, 15) == 0);
         bus.jmp_addr  = 6'($urandom_range(0, 63));
         tick();
      end
      idle_inputs();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-supply stage directly upstream of the processor core; drives the core's 14-bit instruction input each cycle.
- Holds a loadable program memory, a program counter and a small run-control FSM.
- Supports stall and jump/flush from the core, an external abort, and an in-band HALT opcode.
- Replaces bench-driven instruction streams with a self-sequencing fetch path.

Parameters:
- IW, 14, instruction width: {opcode[13:10], reg[9:8], imm[7:0]}
- AW, 6, program address width; memory depth 2**AW words

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, active-low asynchronous
- prog_we  in  1  program-memory write strobe; honoured only in IDLE/DONE
- prog_addr  in  AW  program write address
- prog_data  in  IW  program write data
- start  in  1  begin execution from address 0; honoured only in IDLE/DONE
- halt_req  in  1  abort execution
- stall  in  1  core back-pressure; hold current instruction
- jmp_en  in  1  redirect fetch
- jmp_addr  in  AW  jump target
- instr  out  IW  instruction to core
- instr_valid  out  1  instr is a real program word
- pc  out  AW  address of next word to fetch
- running  out  1  FSM in RUN
- done  out  1  FSM in DONE

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst=0, any state, mid-run included):
  - state=IDLE, pc=0, instr=NOP_INSTR (14'h3800), instr_valid=0, running=0, done=0.
  - Memory contents are not cleared.
- Memory: synchronous write; read is combinational from pc and registered into instr.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE:
  - prog_we writes mem[prog_addr]=prog_data.
  - start=1 -> RUN with pc=0; instr=NOP, valid=0.
  - prog_we and start in the same cycle: write takes effect, then RUN begins.
- RUN, per edge, in priority order:
  1. halt_req=1 -> DONE; instr=NOP, valid=0; pc holds.
  2. jmp_en=1 (overrides stall) -> pc=jmp_addr; instr=NOP, valid=0 (one-cycle flush bubble).
  3. stall=1 -> instr, instr_valid and pc hold.
  4. mem[pc][13:10]==4'hF (HALT) -> HALT word not forwarded; instr=NOP, valid=0; pc holds at HALT address; next state DONE.
  5. Otherwise -> instr=mem[pc], valid=1, pc=pc+1 mod 2**AW (wrap from 2**AW-1 to 0, no error).
- Latency: start sampled at edge N; mem[0] is on instr with valid=1 after edge N+1; one word per cycle thereafter.
- Writes and start are ignored in RUN; no read/write collision is possible.
- running=1 iff state==RUN; done=1 iff state==DONE (registered).
- Opcode 4'hE is NOP; the core may execute it as a no-op.

Optional Feature:
- Macro FETCH_LOOP_EN.
- Defined: HALT opcode in RUN sets pc=0 and stays in RUN, with one NOP bubble (valid=0). halt_req still goes to DONE.
- Undefined: HALT goes to DONE as above.

Decomposition:
- Shared package isa_pkg: OPC_NOP=4'hE, OPC_HALT=4'hF, NOP_INSTR=14'h3800, field-position constants, and the fetch FSM state enum.
- One sub-module, prog_mem: parameterised AW x IW RAM with synchronous write and asynchronous read.
- FSM and PC stay in the top module.

Test Plan:
- Load mem[0..3]=14'h2801, 14'h2902, 14'h2A03, 14'h3C00; pulse start -> instr 2801, 2902, 2A03 on consecutive cycles with valid=1; then valid=0, instr=3800, done=1, pc=3.
- Stall held 3 cycles while instr=14'h2902 -> instr/pc frozen for 3 cycles; resumes with 14'h2A03; no word lost or duplicated.
- jmp_en with jmp_addr=6'h10 while stall=1, mem[16]=14'h2FC0 -> one bubble (valid=0), then instr=2FC0, pc=6'h11.
- Fill all 64 words with 14'h2FC0 (no HALT) -> after pc=63 fetch, pc wraps to 0; valid stays 1.
- Assert rst low mid-run, and halt_req mid-run in a separate run -> rst: immediately IDLE, pc=0, valid=0 while rst is low; halt_req: DONE next edge. prog_we in RUN is ignored (readback after DONE is unchanged).
- FETCH_LOOP_EN defined, program ending in 14'h3C00 -> pc returns to 0, one bubble, sequence repeats; done stays 0.
